// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch stage with PC ownership, imem req/gnt interface and in-order response FIFO
//
// Ports:
//    clk_i, rst_i           clock, asynchronous active-high reset
//    stall_i                decode holding, head is not consumed
//    redirect_i/_pc_i       taken branch/jump, kills everything in flight
//    imem_req_o/_addr_o     memory request and its address
//    imem_gnt_i             request accepted this cycle
//    imem_rvalid_i/_rdata_i in-order response
//    fetch_valid_o          instr_f_o/pc_f_o/pc_plus_4_f_o hold a live instruction
//
// Optional feature: define FETCH_BYPASS_EN to forward a live response straight to
// the outputs when the FIFO is empty (grant N -> valid N+1 instead of N+2).
module fetch_unit #(
   parameter int             DW         = 32,
   parameter logic [DW-1:0]  RESET_PC   = '0,
   parameter int             FIFO_DEPTH = 2
) (
   input  logic          clk_i,
   input  logic          rst_i,
   input  logic          stall_i,
   input  logic          redirect_i,
   input  logic [DW-1:0] redirect_pc_i,
   output logic          imem_req_o,
   output logic [DW-1:0] imem_addr_o,
   input  logic          imem_gnt_i,
   input  logic          imem_rvalid_i,
   input  logic [DW-1:0] imem_rdata_i,
   output logic          fetch_valid_o,
   output logic [DW-1:0] instr_f_o,
   output logic [DW-1:0] pc_f_o,
   output logic [DW-1:0] pc_plus_4_f_o
);
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int CW = $clog2(FIFO_DEPTH + 1);
   localparam logic [DW-1:0] NOP = DW'(32'h13);

   logic [DW-1:0] req_pc;
   logic [CW-1:0] inflight, discard, count, inflight_n;
   logic [AW-1:0] rd_ptr, wr_ptr, tag_rd, tag_wr;
   logic [DW-1:0] fifo_pc [FIFO_DEPTH];
   logic [DW-1:0] fifo_ins [FIFO_DEPTH];
   logic [DW-1:0] tags [FIFO_DEPTH];
   logic gnt_fire, rsp_fire, rsp_live, bypass, push, pop;
   logic [DW-1:0] head_pc, head_ins;

`ifdef FETCH_BYPASS_EN
   assign bypass = (count == '0) & rsp_live;
`else
   assign bypass = 1'b0;
`endif

   always_comb begin
      // credit covers both outstanding requests and buffered words, so a granted response always has a slot
      imem_req_o    = ~rst_i & ((int'(inflight) + int'(count)) < FIFO_DEPTH);
      imem_addr_o   = req_pc;
      gnt_fire      = imem_req_o & imem_gnt_i;
      // an rvalid with nothing outstanding is a protocol error and is ignored
      rsp_fire      = imem_rvalid_i & (inflight != '0);
      rsp_live      = rsp_fire & (discard == '0);
      inflight_n    = inflight + CW'(gnt_fire) - CW'(rsp_fire);
      fetch_valid_o = (count != '0) | bypass;
      pop           = (count != '0) & ~stall_i & ~redirect_i;
      // a bypassed word consumed in the same cycle never enters the FIFO
      push          = rsp_live & ~redirect_i & ~(bypass & ~stall_i);
      head_pc       = (count != '0) ? fifo_pc[rd_ptr] : tags[tag_rd];
      head_ins      = (count != '0) ? fifo_ins[rd_ptr] : imem_rdata_i;
      instr_f_o     = fetch_valid_o ? head_ins : NOP;
      pc_f_o        = fetch_valid_o ? head_pc : '0;
      pc_plus_4_f_o = fetch_valid_o ? head_pc + DW'(4) : '0;
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         req_pc   <= RESET_PC;
         inflight <= '0;
         discard  <= '0;
         count    <= '0;
         rd_ptr   <= '0;
         wr_ptr   <= '0;
         tag_rd   <= '0;
         tag_wr   <= '0;
      end else begin
         inflight <= inflight_n;
         if (redirect_i) begin
            // every request still outstanding after this edge belongs to the killed path
            req_pc  <= redirect_pc_i;
            discard <= inflight_n;
            count   <= '0;
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            tag_rd  <= '0;
            tag_wr  <= '0;
         end else begin
            if (gnt_fire) begin
               req_pc <= req_pc + DW'(4);
               tag_wr <= tag_wr + 1'b1;
            end
            if (rsp_fire && discard != '0) discard <= discard - 1'b1;
            if (rsp_live) tag_rd <= tag_rd + 1'b1;
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            count <= count + CW'(push) - CW'(pop);
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (gnt_fire && !redirect_i) tags[tag_wr] <= req_pc;
      if (push) begin
         fifo_pc[wr_ptr]  <= tags[tag_rd];
         fifo_ins[wr_ptr] <= imem_rdata_i;
      end
   end
endmodule
